// File: rtl/pulse_meas.sv
// rtl/pulse_meas.sv - ISERDES word pulse width/gap measurement
// Optional glitch filter enabled by defining PULSE_MEAS_FILTER_EN.
module pulse_meas #(
    parameter int CLK_PER_US = 125,
    parameter int GAP_W      = 24,
    parameter int MIN_WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din_i,
    input  logic             din_valid_i,
    input  logic             start_i,
    input  logic [10:0]      pulse_num_i,
    input  logic [15:0]      timeout_us_i,
    output logic             meas_valid_o,
    output logic [10:0]      width_o,
    output logic [GAP_W-1:0] gap_o,
    output logic [10:0]      pulse_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             glitch_o
);
`ifdef PULSE_MEAS_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam int               CYC_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_US - 1);
    localparam logic [10:0]      W_MAX    = '1;
    localparam logic [GAP_W-1:0] G_MAX    = '1;
    localparam logic [10:0]      MIN_W    = 11'(MIN_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_RISE, S_HIGH, S_LOW, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [10:0]      high_run_q, high_run_d, count_q, count_d, pnum_q, pnum_d;
    logic [GAP_W-1:0] low_run_q, low_run_d, gap_q, gap_d;
    logic [15:0]      tmo_q, tmo_d, us_q, us_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             start_q;
    logic             meas_valid_q, meas_valid_d, done_q, done_d;
    logic             timeout_q, timeout_d, glitch_q, glitch_d;
    logic [10:0]      width_q, width_d, idx_q, idx_d;
    logic [GAP_W-1:0] gapo_q, gapo_d;

    always_comb begin
        state_t           st;
        logic [10:0]      hr, cnt;
        logic [GAP_W-1:0] lr, gp;
        logic [GAP_W:0]   lsum;
        logic             rep, edge_seen, fin, glitch;

        st = state_q;  hr = high_run_q;  lr = low_run_q;  gp = gap_q;  cnt = count_q;
        lsum = '0;  rep = 1'b0;  edge_seen = 1'b0;  fin = 1'b0;  glitch = 1'b0;
        state_d = state_q;  high_run_d = high_run_q;  low_run_d = low_run_q;  gap_d = gap_q;
        count_d = count_q;  pnum_d = pnum_q;  tmo_d = tmo_q;  us_d = us_q;  cyc_d = cyc_q;
        meas_valid_d = 1'b0;  width_d = width_q;  gapo_d = gapo_q;  idx_d = idx_q;
        done_d = (state_q == S_DONE);  timeout_d = timeout_q;  glitch_d = glitch_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !start_q) begin
                    pnum_d    = pulse_num_i;
                    tmo_d     = timeout_us_i;
                    timeout_d = 1'b0;
                    glitch_d  = 1'b0;
                    count_d   = '0;
                    state_d   = (pulse_num_i == 11'd0) ? S_DONE : S_ARM;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (din_valid_i) begin
                    // One word per cycle; after the first report the rest of the word is
                    // still tracked so the run counters end at the word's final level.
                    for (int i = 0; i < 8; i++) begin
                        case (st)
                            S_ARM: if (!din_i[i]) st = S_WAIT_RISE;
                            S_WAIT_RISE, S_LOW: begin
                                if (din_i[i]) begin
                                    gp = (st == S_LOW) ? lr : '0;
                                    hr = 11'd1;
                                    st = S_HIGH;
                                    edge_seen = 1'b1;
                                end else if (st == S_LOW && lr != G_MAX) begin
                                    lr = lr + GAP_W'(1);
                                end
                            end
                            S_HIGH: begin
                                if (din_i[i]) begin
                                    if (hr != W_MAX) hr = hr + 11'd1;
                                end else begin
                                    edge_seen = 1'b1;
                                    if (rep) glitch = 1'b1;
                                    if (FILTER_EN && hr < MIN_W) begin
                                        lsum = {1'b0, lr} + (GAP_W+1)'(hr) + (GAP_W+1)'(1);
                                        lr   = lsum[GAP_W] ? G_MAX : lsum[GAP_W-1:0];
                                        st   = (cnt == 11'd0) ? S_WAIT_RISE : S_LOW;
                                    end else if (rep) begin
                                        lr = GAP_W'(1);
                                        st = S_LOW;
                                    end else begin
                                        rep          = 1'b1;
                                        meas_valid_d = 1'b1;
                                        width_d      = hr;
                                        gapo_d       = gp;
                                        idx_d        = cnt;
                                        cnt          = cnt + 11'd1;
                                        lr           = GAP_W'(1);
                                        st           = S_LOW;
                                        if (cnt == pnum_q) fin = 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                    state_d    = fin ? S_DONE : st;
                    high_run_d = hr;
                    low_run_d  = lr;
                    gap_d      = gp;
                    count_d    = cnt;
                    if (glitch) glitch_d = 1'b1;
                end

                // Idle timer: counts wall-clock cycles, restarted by any edge; edges beat expiry.
                if (state_q == S_ARM) begin
                    cyc_d = '0;
                    us_d  = '0;
                end else if (edge_seen) begin
                    cyc_d = CYC_W'(1);
                    us_d  = '0;
                end else if (cyc_q >= CYC_LAST) begin
                    cyc_d = '0;
                    us_d  = us_q + 16'd1;
                    if (tmo_q != 16'd0 && ({1'b0, us_q} + 17'd1) == {1'b0, tmo_q}) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;  high_run_q <= '0;  low_run_q <= '0;  gap_q <= '0;
            count_q <= '0;  pnum_q <= '0;  tmo_q <= '0;  us_q <= '0;  cyc_q <= '0;
            start_q <= 1'b0;  meas_valid_q <= 1'b0;  width_q <= '0;  gapo_q <= '0;
            idx_q <= '0;  done_q <= 1'b0;  timeout_q <= 1'b0;  glitch_q <= 1'b0;
        end else begin
            state_q <= state_d;  high_run_q <= high_run_d;  low_run_q <= low_run_d;
            gap_q <= gap_d;  count_q <= count_d;  pnum_q <= pnum_d;  tmo_q <= tmo_d;
            us_q <= us_d;  cyc_q <= cyc_d;  start_q <= start_i;
            meas_valid_q <= meas_valid_d;  width_q <= width_d;  gapo_q <= gapo_d;
            idx_q <= idx_d;  done_q <= done_d;  timeout_q <= timeout_d;  glitch_q <= glitch_d;
        end
    end

    assign meas_valid_o = meas_valid_q;
    assign width_o      = width_q;
    assign gap_o        = gapo_q;
    assign pulse_idx_o  = idx_q;
    assign busy_o       = (state_q == S_ARM) || (state_q == S_WAIT_RISE) ||
                          (state_q == S_HIGH) || (state_q == S_LOW);
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign glitch_o     = glitch_q;

endmodule

// File: tb/tb_pulse_meas.sv
// tb/tb_pulse_meas.sv - self-checking bench for pulse_meas
module tb_pulse_meas;
    localparam int GAP_W = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       din_i = '0;
    logic             din_valid_i = 1'b0;
    logic             start_i = 1'b0;
    logic [10:0]      pulse_num_i = '0;
    logic [15:0]      timeout_us_i = '0;
    logic             meas_valid_o, busy_o, done_o, timeout_o, glitch_o;
    logic [10:0]      width_o, pulse_idx_o;
    logic [GAP_W-1:0] gap_o;

    always #5 clk = ~clk;

    pulse_meas #(.CLK_PER_US(125), .GAP_W(GAP_W), .MIN_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_valid_i(din_valid_i),
        .start_i(start_i), .pulse_num_i(pulse_num_i), .timeout_us_i(timeout_us_i),
        .meas_valid_o(meas_valid_o), .width_o(width_o), .gap_o(gap_o),
        .pulse_idx_o(pulse_idx_o), .busy_o(busy_o), .done_o(done_o),
        .timeout_o(timeout_o), .glitch_o(glitch_o)
    );

    int n_cmp = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0;
    int str_w[$], str_g[$], str_i[$], str_c[$];

    always @(negedge clk) begin
        if (meas_valid_o) begin
            str_w.push_back(int'(width_o));
            str_g.push_back(int'(gap_o));
            str_i.push_back(int'(pulse_idx_o));
            str_c.push_back(cyc);
        end
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic v);
        din_i = w;
        din_valid_i = v;
        tick();
    endtask

    task automatic idle(input int n);
        din_valid_i = 1'b0;
        din_i = '0;
        repeat (n) tick();
    endtask

    task automatic start_cap(input int pn, input int tmo);
        pulse_num_i = 11'(pn);
        timeout_us_i = 16'(tmo);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int db, input int budget, input string name);
        int k = 0;
        while (done_cnt == db && k < budget) begin
            tick();
            k++;
        end
        tick();
        check(name, done_cnt - db, 1);
    endtask

    task automatic check_strobe(input string name, input int pos, input int w, input int g, input int i);
        check({name, "_width"}, str_w[pos], w);
        check({name, "_gap"}, str_g[pos], g);
        check({name, "_idx"}, str_i[pos], i);
    endtask

    typedef struct {
        logic [31:0] words;
        int          exp_w;
        int          exp_glitch;
    } vec_t;

    task automatic run_table();
        vec_t tbl[6];
        tbl[0] = '{32'h0FFF_FF00, 20, 0};
        tbl[1] = '{32'h0000_3800, 3, 0};
        tbl[2] = '{32'h01FF_8000, 10, 0};
        tbl[3] = '{32'h0000_7700, 3, 1};
        tbl[4] = '{32'h3C0F_FFFF, 4, 0};
        tbl[5] = '{32'h0000_FC00, 6, 0};
        for (int t = 0; t < 6; t++) begin
            int sb = str_w.size();
            int db = done_cnt;
            logic [31:0] ws = tbl[t].words;
            start_cap(1, 0);
            for (int j = 0; j < 4; j++) send(ws[8*j +: 8], 1'b1);
            send(8'h00, 1'b1);
            idle(1);
            wait_done(db, 20, $sformatf("tbl%0d_done", t));
            check($sformatf("tbl%0d_nstrobe", t), str_w.size() - sb, 1);
            check_strobe($sformatf("tbl%0d", t), sb, tbl[t].exp_w, 0, 0);
            check($sformatf("tbl%0d_done_lat", t), done_cyc - str_c[sb], 1);
            check($sformatf("tbl%0d_glitch", t), glitch_o, tbl[t].exp_glitch);
            check($sformatf("tbl%0d_timeout", t), timeout_o, 0);
        end
    endtask

    task automatic run_train();
        int sb = str_w.size();
        int db = done_cnt;
        start_cap(3, 0);
        send(8'h00, 1'b1);
        for (int p = 0; p < 3; p++) begin
            send(8'hF0, 1'b1);
            pulse_num_i = 11'd1;
            start_i = (p == 1);
            send(8'hFF, 1'b1);
            start_i = 1'b0;
            repeat (4) send(8'h00, 1'b1);
        end
        idle(1);
        wait_done(db, 20, "train_done");
        check("train_nstrobe", str_w.size() - sb, 3);
        check_strobe("train0", sb, 12, 0, 0);
        check_strobe("train1", sb + 1, 12, 36, 1);
        check_strobe("train2", sb + 2, 12, 36, 2);
        check("train_done_lat", done_cyc - str_c[sb + 2], 1);
    endtask

    task automatic run_pair();
        int sb = str_w.size();
        int db = done_cnt;
`ifdef PULSE_MEAS_FILTER_EN
        logic [7:0] pw = 8'h77;
        int w1 = 3;
`else
        logic [7:0] pw = 8'h66;
        int w1 = 2;
`endif
        start_cap(2, 0);
        send(8'h00, 1'b1);
        send(pw, 1'b1);
        send(8'h00, 1'b1);
        send(8'h3C, 1'b1);
        send(8'h00, 1'b1);
        idle(1);
        wait_done(db, 20, "pair_done");
        check("pair_nstrobe", str_w.size() - sb, 2);
        check_strobe("pair0", sb, w1, 0, 0);
        check_strobe("pair1", sb + 1, 4, 11, 1);
        check("pair_glitch", glitch_o, 1);
    endtask

    task automatic run_timeout();
        int sb = str_w.size();
        int db = done_cnt;
        int k = 0;
        int delta;
        start_cap(2, 2);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        while (done_cnt == db && k < 400) begin
            send(8'h00, 1'($urandom_range(0, 1)));
            k++;
        end
        idle(2);
        check("tmo_done", done_cnt - db, 1);
        check("tmo_nstrobe", str_w.size() - sb, 1);
        check("tmo_flag", timeout_o, 1);
        delta = done_cyc - str_c[sb];
        n_cmp++;
        if (delta < 249 || delta > 251) begin
            n_err++;
            $display("FAIL tmo_latency: got %0d cycles, expected 250 +/- 1", delta);
        end
    endtask

    task automatic run_reset();
        int sb, db;
        start_cap(1, 0);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        check("rst_busy_before", busy_o, 1);
        rst_n = 1'b0;
        send(8'h00, 1'b1);
        check("rst_meas_valid", meas_valid_o, 0);
        check("rst_width", width_o, 0);
        check("rst_gap", gap_o, 0);
        check("rst_idx", pulse_idx_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_glitch", glitch_o, 0);
        db = done_cnt;
        rst_n = 1'b1;
        idle(5);
        check("rst_no_done", done_cnt - db, 0);
        sb = str_w.size();
        start_cap(1, 0);
        send(8'h00, 1'b1);
        send(8'h3C, 1'b1);
        send(8'h00, 1'b1);
        idle(1);
        wait_done(db, 20, "rst_recap_done");
        check("rst_recap_nstrobe", str_w.size() - sb, 1);
        check_strobe("rst_recap", sb, 4, 0, 0);
    endtask

    task automatic run_misc();
        int sb = str_w.size();
        int db = done_cnt;
        start_cap(0, 0);
        idle(1);
        wait_done(db, 10, "zero_done");
        check("zero_nstrobe", str_w.size() - sb, 0);
        check("zero_busy", busy_o, 0);

        sb = str_w.size();
        db = done_cnt;
        start_cap(1, 0);
        send(8'h00, 1'b1);
        repeat (260) send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        idle(1);
        wait_done(db, 10, "sat_done");
        check_strobe("sat", sb, 2047, 0, 0);

        sb = str_w.size();
        db = done_cnt;
        start_cap(2, 0);
        send(8'h00, 1'b1);
        send(8'h3C, 1'b1);
        send(8'h06, 1'b1);
        send(8'h00, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h00, 1'b1);
        idle(1);
        wait_done(db, 10, "filt_done");
        check("filt_nstrobe", str_w.size() - sb, 2);
        check_strobe("filt0", sb, 4, 0, 0);
`ifdef PULSE_MEAS_FILTER_EN
        check_strobe("filt1", sb + 1, 4, 22, 1);
`else
        check_strobe("filt1", sb + 1, 2, 3, 1);
`endif
    endtask

    // Random trains: runs >= 4 samples keep at most one falling edge per word.
    task automatic run_random(input int trials);
        for (int t = 0; t < trials; t++) begin
            int np = $urandom_range(1, 5);
            int ew[$], eg[$];
            bit smp[$];
            int prev_l = 0;
            bit prev = 1'b0;
            int sb, db;
            repeat ($urandom_range(4, 20)) smp.push_back(1'b0);
            for (int p = 0; p < np; p++) begin
                int h = $urandom_range(4, 40);
                int l = $urandom_range(4, 40);
                ew.push_back(h);
                eg.push_back(p == 0 ? 0 : prev_l);
                repeat (h) smp.push_back(1'b1);
                repeat (l) smp.push_back(1'b0);
                prev_l = l;
            end
            while (smp.size() % 8 != 0) smp.push_back(1'b0);
            repeat (8) smp.push_back(1'b0);
            sb = str_w.size();
            db = done_cnt;
            start_cap(np, 0);
            for (int w = 0; w < smp.size() / 8; w++) begin
                logic [7:0] word;
                bit has_fall = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    word[b] = smp[8*w + b];
                    if (prev && !smp[8*w + b]) has_fall = 1'b1;
                    prev = smp[8*w + b];
                end
                while ($urandom_range(0, 3) == 0) begin
                    send(8'($urandom), 1'b0);
                    check("rnd_lat_idle", meas_valid_o, 0);
                end
                send(word, 1'b1);
                check("rnd_lat_word", meas_valid_o, has_fall);
            end
            idle(1);
            wait_done(db, 10, "rnd_done");
            check("rnd_nstrobe", str_w.size() - sb, np);
            for (int p = 0; p < np && sb + p < str_w.size(); p++)
                check_strobe($sformatf("rnd%0d_%0d", t, p), sb + p, ew[p], eg[p], p);
            check("rnd_glitch", glitch_o, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_meas_valid", meas_valid_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_width", width_o, 0);
        rst_n = 1'b1;
        idle(2);
        run_table();
        run_train();
        run_pair();
        run_timeout();
        run_reset();
        run_misc();
        run_random(25);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_err);
        $fatal(1);
    end

endmodule
